// File: rtl/scan_sequencer_if.sv
// Scan sequencer control/status bundle: scan request inputs and decoder-drive outputs.
// Latency: none, wires only.
// Backpressure: none; start is only sampled while the sequencer is idle.
interface scan_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic [7:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic               continuous;
    logic               stop;
    logic [2:0]         sel;
    logic               en;
    logic               busy;
    logic               done;

    // Requester side drives the scan request and watches status.
    modport master (
        output start, mask, dwell, continuous, stop,
        input  sel, en, busy, done
    );

    // Sequencer side consumes the request and drives the decoder outputs.
    modport slave (
        input  start, mask, dwell, continuous, stop,
        output sel, en, busy, done
    );
endinterface

// File: rtl/scan_sequencer.sv
// Channel scan sequencer: walks the enabled channels of an 8-bit mask, driving each for dwell cycles.
// Latency: start accepted in cycle 0 -> SEEK in cycle 1 -> first channel driven (en=1) in cycle 2.
// Backpressure: start is ignored while busy; stop aborts a scan on the next edge.
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    scan_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        DWELL = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;
    logic [3:0]         ptr_q, ptr_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [2:0]         sel_q, sel_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               fwd_hit;
    logic [2:0]         fwd_idx;
    logic [2:0]         any_idx;

    // Priority search: lowest set mask bit at or above ptr, and lowest set bit overall for wrap.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_idx = 3'd0;
        any_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) begin
                any_idx = 3'(i);
                if (4'(i) >= ptr_q) begin
                    fwd_hit = 1'b1;
                    fwd_idx = 3'(i);
                end
            end
        end
    end

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.mask != 8'h00) begin
                        mask_d  = bus.mask;
                        // A zero dwell would underflow the counter; treat it as one cycle.
                        dwell_d = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
                        cont_d  = bus.continuous;
                        ptr_d   = 4'd0;
                        busy_d  = 1'b1;
                        state_d = SEEK;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            SEEK: begin
                if (bus.stop || (!fwd_hit && !cont_q)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    sel_d   = fwd_hit ? fwd_idx : any_idx;
                    cnt_d   = dwell_q - DWELL_W'(1);
                    en_d    = 1'b1;
                    state_d = DWELL;
                end
            end
            DWELL: begin
                if (bus.stop) begin
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    // ptr is 4 bits so that finishing channel 7 leaves ptr=8 (nothing ahead).
                    ptr_d   = 4'(sel_q) + 4'd1;
                    en_d    = 1'b0;
                    state_d = SEEK;
                end else begin
                    cnt_d   = cnt_q - DWELL_W'(1);
                end
            end
            default: begin
                en_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= 8'h00;
            dwell_q <= DWELL_W'(1);
            cont_q  <= 1'b0;
            ptr_q   <= 4'd0;
            cnt_q   <= '0;
            sel_q   <= 3'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sel  = sel_q;
    assign bus.en   = en_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: hand-computed per-cycle expectations for several scans.
// Latency: checks sample outputs 2 time units after each rising edge.
// Backpressure: exercises ignored mid-scan starts and stop aborts.
module tb_scan_sequencer;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    int   q_en[$];
    int   q_sel[$];
    int   q_busy[$];
    int   q_done[$];

    scan_sequencer_if #(.DWELL_W(8)) bus ();

    scan_sequencer #(.DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    // Cycle 0 issues start; cycles 1..ncyc are checked against the q_* tables (index = cycle).
    task automatic run_scan(input string name, input logic [7:0] m, input logic [7:0] d,
                            input logic c, input int ncyc, input int stop_at, input int start2_at);
        next_cyc();
        bus.start      = 1'b1;
        bus.mask       = m;
        bus.dwell      = d;
        bus.continuous = c;
        bus.stop       = 1'b0;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            next_cyc();
            bus.start      = 1'b0;
            bus.mask       = 8'h5A;
            bus.dwell      = 8'd9;
            bus.continuous = ~c;
            bus.stop       = (cyc == stop_at);
            if (cyc == start2_at) begin
                bus.start = 1'b1;
                bus.mask  = 8'hFF;
            end
            chk($sformatf("%s c%0d en", name, cyc),   32'(bus.en),   32'(q_en[cyc]));
            chk($sformatf("%s c%0d sel", name, cyc),  32'(bus.sel),  32'(q_sel[cyc]));
            chk($sformatf("%s c%0d busy", name, cyc), 32'(bus.busy), 32'(q_busy[cyc]));
            chk($sformatf("%s c%0d done", name, cyc), 32'(bus.done), 32'(q_done[cyc]));
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    initial begin
        n_vec          = 0;
        n_bad          = 0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.mask       = 8'h00;
        bus.dwell      = 8'd0;
        bus.continuous = 1'b0;
        bus.stop       = 1'b0;

        // Reset state before any clock edge.
        #3;
        chk("rst sel",  32'(bus.sel),  32'd0);
        chk("rst en",   32'(bus.en),   32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        #4;
        rst_n = 1'b1;

        // mask 85, dwell 3, one-shot; an FF start mid-scan must be ignored.
        q_en   = '{0, 0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 0};
        q_sel  = '{0, 0, 0, 0, 0, 0, 2, 2, 2, 2, 7, 7, 7, 7, 7};
        q_busy = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        q_done = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        run_scan("m85", 8'h85, 8'd3, 1'b0, 14, -1, 7);

        // mask 03, dwell 0 behaves as dwell 1.
        q_en   = '{0, 0, 1, 0, 1, 0, 0};
        q_sel  = '{0, 7, 0, 0, 1, 1, 1};
        q_busy = '{0, 1, 1, 1, 1, 1, 0};
        q_done = '{0, 0, 0, 0, 0, 0, 1};
        run_scan("m03", 8'h03, 8'd0, 1'b0, 6, -1, -1);

        // mask 80, continuous: same channel repeats with a break; stop at expiry wins.
        q_en   = '{0, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
        q_sel  = '{0, 1, 7, 7, 7, 7, 7, 7, 7, 7, 7};
        q_busy = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        q_done = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        run_scan("m80a", 8'h80, 8'd2, 1'b1, 10, 9, -1);

        // mask 80, continuous, stop in cycle 6; done pulses only once.
        q_en   = '{0, 0, 1, 1, 0, 1, 1, 0, 0};
        q_sel  = '{0, 7, 7, 7, 7, 7, 7, 7, 7};
        q_busy = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
        q_done = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        run_scan("m80b", 8'h80, 8'd2, 1'b1, 8, 6, -1);

        // Empty mask: immediate done, never busy.
        q_en   = '{0, 0, 0};
        q_sel  = '{0, 7, 7};
        q_busy = '{0, 0, 0};
        q_done = '{0, 1, 0};
        run_scan("m00", 8'h00, 8'd4, 1'b0, 2, -1, -1);

        // Asynchronous reset in the middle of a dwell.
        next_cyc();
        bus.start      = 1'b1;
        bus.mask       = 8'h10;
        bus.dwell      = 8'd5;
        bus.continuous = 1'b0;
        next_cyc();
        bus.start = 1'b0;
        next_cyc();
        next_cyc();
        chk("pre-rst en",  32'(bus.en),  32'd1);
        chk("pre-rst sel", 32'(bus.sel), 32'd4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst en",   32'(bus.en),   32'd0);
        chk("arst busy", 32'(bus.busy), 32'd0);
        chk("arst sel",  32'(bus.sel),  32'd0);
        chk("arst done", 32'(bus.done), 32'd0);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cyc();
            chk($sformatf("post-rst done c%0d", k), 32'(bus.done), 32'd0);
            chk($sformatf("post-rst busy c%0d", k), 32'(bus.busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, the width of the dwell-count input.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: begin a scan; sampled only in IDLE.
REQ-005 SHALL have port mask, input, 8 bits: channel enable mask; bit i enables channel i; latched on an accepted start.
REQ-006 SHALL have port dwell, input, DWELL_W bits: number of cycles each channel is driven; latched on an accepted start.
REQ-007 SHALL have port continuous, input, 1 bit: 1 = wrap and rescan indefinitely; latched on an accepted start.
REQ-008 SHALL have port stop, input, 1 bit: abort the active scan.
REQ-009 SHALL have port sel, output, 3 bits: channel index for the downstream 3-to-8 decoder.
REQ-010 SHALL have port en, output, 1 bit: decoder enable; 1 only while a channel is being driven.
REQ-011 SHALL have port busy, output, 1 bit: scan in progress.
REQ-012 SHALL have port done, output, 1 bit: single-cycle end-of-scan pulse.

Function
REQ-013 SHALL implement the states IDLE, SEEK and DWELL; busy=1 exactly in SEEK and DWELL.
REQ-014 IDLE, on start=1 with mask!=0, SHALL latch the following, then go to SEEK:
- mask_r = mask.
- dwell_r = dwell, with 0 replaced by 1.
- cont_r = continuous.
- 4-bit ptr = 0.
REQ-015 IDLE, on start=1 with mask==0, SHALL stay in IDLE and assert done in the next cycle.
REQ-016 SEEK SHALL last exactly one cycle with en=0 and select the lowest set bit of mask_r at index >= ptr.
REQ-017 SEEK, if no such bit exists and cont_r=1, SHALL wrap and select the lowest set bit of mask_r.
REQ-018 SEEK, if no such bit exists and cont_r=0, SHALL go to IDLE.
REQ-019 On a selection in SEEK, the following SHALL happen, then the block SHALL go to DWELL:
- sel takes the selected index.
- The down-counter loads dwell_r-1.
REQ-020 DWELL SHALL hold en=1 and sel constant, decrementing the counter each cycle.
REQ-021 DWELL, when the counter is 0, SHALL set ptr=sel+1 (4-bit, so ptr=8 after channel 7) and go to SEEK.
REQ-022 stop=1 in SEEK or DWELL SHALL force IDLE on the next edge, overriding dwell expiry and selection.
REQ-023 done SHALL be 1 for exactly one cycle:
- the first IDLE cycle after any scan end (normal or stop), or
- per REQ-015.
REQ-024 start while busy=1 SHALL be ignored; mask, dwell and continuous changes mid-scan SHALL have no effect.
REQ-025 en SHALL be 0 in every IDLE and SEEK cycle, guaranteeing a one-cycle break between channels, including same-channel repeats.
REQ-026 sel SHALL hold its last value in IDLE and SEEK.
REQ-027 Latency SHALL be: start accepted at cycle 0 -> SEEK in cycle 1 -> en=1 in cycle 2.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst_n=0 SHALL immediately force the following, regardless of clk:
- state=IDLE.
- sel=0, en=0, busy=0, done=0.
- ptr=0, counter=0, mask_r=0, dwell_r=1, cont_r=0.
REQ-030 After rst_n rises, the first start SHALL be accepted on the first rising clk edge.

Verification
REQ-031 mask=8'h85, dwell=3, continuous=0, start at cycle 0 SHALL produce:
- en=1 with sel=0 in cycles 2-4.
- en=1 with sel=2 in cycles 6-8.
- en=1 with sel=7 in cycles 10-12.
- en=0 in cycles 5, 9 and 13.
- done=1 and busy=0 in cycle 14.
REQ-032 mask=8'h03, dwell=0 SHALL produce:
- en=1 with sel=0 in cycle 2.
- en=1 with sel=1 in cycle 4.
- done in cycle 6.
REQ-033 mask=8'h80, dwell=2, continuous=1 SHALL produce:
- en=1 with sel=7 in cycles 2-3, 5-6 and 8-9; done never asserts.
- stop in cycle 6 -> cycle 7 has en=0, busy=0, done=1.
REQ-034 start with mask=8'h00 at cycle 0 SHALL produce done=1 in cycle 1, with busy and en remaining 0.
REQ-035 rst_n=0 mid-DWELL SHALL drop en, busy and sel to 0 without a clock edge, and done SHALL not pulse.
REQ-036 A start pulse with mask=8'hFF during an active scan SHALL not alter sel or timing.
